// File: rtl/xbip_dsp48_macro.sv
// xbip_dsp48_macro: 3-stage signed P=(A+D)*B+C MAC; XBIP_DSP48_MACRO_CE_EN adds a CE clock-enable port
module xbip_dsp48_macro (
  input  logic               CLK,
  input  logic               SCLR,
`ifdef XBIP_DSP48_MACRO_CE_EN
  input  logic               CE,
`endif
  input  logic signed [24:0] A,
  input  logic signed [17:0] B,
  input  logic signed [47:0] C,
  input  logic signed [24:0] D,
  output logic signed [47:0] P
);
  logic w_ce;
`ifdef XBIP_DSP48_MACRO_CE_EN
  assign w_ce = CE;
`else
  assign w_ce = 1'b1;
`endif
  logic signed [24:0] r_ad1;
  logic signed [17:0] r_b1;
  logic signed [47:0] r_c1, r_c2, r_p;
  logic signed [42:0] r_m2;
  always_ff @(posedge CLK)
    if (SCLR) begin
      r_ad1 <= '0;
      r_b1  <= '0;
      r_c1  <= '0;
      r_m2  <= '0;
      r_c2  <= '0;
      r_p   <= '0;
    end else if (w_ce) begin
      r_ad1 <= A + D;
      r_b1  <= B;
      r_c1  <= C;
      r_m2  <= 43'(r_ad1) * 43'(r_b1);
      r_c2  <= r_c1;
      r_p   <= 48'(r_m2) + r_c2;
    end
  assign P = r_p;
endmodule

// File: tb/tb_xbip_dsp48_macro.sv
// tb_xbip_dsp48_macro: randomized scoreboard bench for xbip_dsp48_macro (CE tests under XBIP_DSP48_MACRO_CE_EN)
module tb_xbip_dsp48_macro;
  logic clk = 1'b0;
  logic sclr;
  logic signed [24:0] a, d;
  logic signed [17:0] b;
  logic signed [47:0] c;
  logic signed [47:0] p;
`ifdef XBIP_DSP48_MACRO_CE_EN
  logic ce;
`endif
  logic [47:0] q[$];
  string tq[$];
  logic [47:0] fl[2];
  logic [47:0] cur;
  int total = 0;
  int pass = 0;
  always #5 clk = ~clk;
  xbip_dsp48_macro dut (
    .CLK(clk),
    .SCLR(sclr),
`ifdef XBIP_DSP48_MACRO_CE_EN
    .CE(ce),
`endif
    .A(a),
    .B(b),
    .C(c),
    .D(d),
    .P(p)
  );
  function automatic logic [47:0] ref_mac(longint ai, longint bi, longint ci, longint di);
    longint ad, r;
    ad = ai + di;
    if (ad >= 64'sd16777216) ad = ad - 64'sd33554432;
    if (ad < -64'sd16777216) ad = ad + 64'sd33554432;
    r = ad * bi + ci;
    return r[47:0];
  endfunction
  task automatic step(input logic signed [24:0] ai, input logic signed [17:0] bi,
                      input logic signed [47:0] ci, input logic signed [24:0] di,
                      input bit rst, input bit en, input string tag);
    a = ai;
    b = bi;
    c = ci;
    d = di;
    sclr = rst;
`ifdef XBIP_DSP48_MACRO_CE_EN
    ce = en;
`endif
    @(posedge clk);
    if (rst) begin
      fl[0] = '0;
      fl[1] = '0;
      cur = '0;
    end else if (en) begin
      cur = fl[0];
      fl[0] = fl[1];
      fl[1] = ref_mac(longint'(ai), longint'(bi), longint'(ci), longint'(di));
    end
    q.push_back(cur);
    tq.push_back(tag);
    #1;
  endtask
  task automatic rnd_step(input bit rst, input bit en, input string tag);
    logic [63:0] w;
    logic [31:0] x, y;
    w = {$urandom(), $urandom()};
    x = $urandom();
    y = $urandom();
    step(x[24:0], y[17:0], w[47:0], y[31:7], rst, en, tag);
  endtask
  initial begin : monitor
    logic [47:0] e;
    string t;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        t = tq.pop_front();
        total++;
        if (p === e) pass++;
        else $display("FAIL %s: P=%0d (0x%h) expected %0d (0x%h)", t, p, p, $signed(e), e);
      end
    end
  end
  initial begin
    step(25'sd0, 18'sd0, 48'sd0, 25'sd0, 1'b1, 1'b1, "reset");
    step(25'sd0, 18'sd0, 48'sd0, 25'sd0, 1'b1, 1'b1, "reset");
    step(25'sd655360, 18'sd1, 48'sd65536, -25'sd10, 1'b0, 1'b1, "packed");
    step(25'sh1000000, 18'sd1, 48'sd0, -25'sd1, 1'b0, 1'b1, "preadd_wrap");
    step(25'sh1000000, 18'sh20000, 48'sd0, 25'sd0, 1'b0, 1'b1, "extreme");
    step(25'sd1, 18'sd1, 48'sh7FFF_FFFF_FFFF, 25'sd0, 1'b0, 1'b1, "postadd_wrap");
    for (int i = 1; i <= 4; i++) step(25'(i), 18'sd1, 48'sd0, 25'sd0, 1'b0, 1'b1, "stream");
    for (int i = 1; i <= 3; i++) step(25'(i), 18'sd1, 48'sd0, 25'sd0, 1'b0, 1'b1, "pre_reset");
    step(25'sd9, 18'sd1, 48'sd0, 25'sd0, 1'b1, 1'b1, "mid_reset");
    for (int i = 5; i <= 10; i++) step(25'(i), 18'sd1, 48'sd0, 25'sd0, 1'b0, 1'b1, "post_release");
    step(25'sd7, 18'sd3, 48'sd5, 25'sd2, 1'b0, 1'b1, "hold");
    for (int i = 0; i < 4; i++) step(25'sd7, 18'sd3, 48'sd5, 25'sd2, 1'b0, 1'b1, "hold");
`ifdef XBIP_DSP48_MACRO_CE_EN
    for (int i = 11; i <= 14; i++) step(25'(i), 18'sd1, 48'sd0, 25'sd0, 1'b0, 1'b1, "ce_stream");
    for (int i = 0; i < 2; i++) step(25'sd99, 18'sd1, 48'sd0, 25'sd0, 1'b0, 1'b0, "ce_freeze");
    for (int i = 15; i <= 18; i++) step(25'(i), 18'sd1, 48'sd0, 25'sd0, 1'b0, 1'b1, "ce_resume");
    step(25'sd0, 18'sd0, 48'sd0, 25'sd0, 1'b1, 1'b0, "ce_off_reset");
    for (int i = 0; i < 3; i++) step(25'sd4, 18'sd4, 48'sd4, 25'sd4, 1'b0, 1'b0, "ce_off_hold");
`endif
    for (int i = 0; i < 400; i++) begin
      bit r, en;
      r = ($urandom_range(0, 24) == 0);
`ifdef XBIP_DSP48_MACRO_CE_EN
      en = ($urandom_range(0, 3) != 0);
`else
      en = 1'b1;
`endif
      rnd_step(r, en, "random");
    end
    for (int i = 0; i < 3; i++) step(25'sd0, 18'sd0, 48'sd0, 25'sd0, 1'b0, 1'b1, "drain");
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() == 0) pass++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
